// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback select and a retired-instruction counter.
// Optional macro WB_BYPASS_EN adds registered copies of the previous register-file write.
module mem_wb_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 Stall_IN,
  input  logic                 Flush_IN,
  input  logic                 Valid_IN,
  input  logic [31:0]          ALUResult_IN,
  input  logic [31:0]          MemData_IN,
  input  logic [31:0]          PCPlus8_IN,
  input  logic [4:0]           DestReg_IN,
  input  logic                 RegWrite_IN,
  input  logic [1:0]           WbSel_IN,
  input  logic [1:0]           LoadSize_IN,
  input  logic                 LoadSigned_IN,
  output logic [31:0]          WriteData_OUT,
  output logic [4:0]           WriteRegister_OUT,
  output logic                 WriteEnable_OUT,
  output logic                 Valid_OUT,
`ifdef WB_BYPASS_EN
  output logic [31:0]          PrevWriteData_OUT,
  output logic [4:0]           PrevWriteRegister_OUT,
  output logic                 PrevWriteEnable_OUT,
`endif
  output logic [CNT_WIDTH-1:0] Retired_OUT
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 valid_r;
  logic [31:0]          alu_r;
  logic [31:0]          mem_r;
  logic [31:0]          pc8_r;
  logic [4:0]           dest_r;
  logic                 regwrite_r;
  logic [1:0]           wbsel_r;
  logic [1:0]           size_r;
  logic                 signed_r;
  logic [CNT_WIDTH-1:0] retired_r;

  logic [31:0]          load_s;
  logic [31:0]          wdata_s;
  logic                 wen_s;

  // Big-endian sub-word extraction; offset 0 addresses the most significant byte.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    r = word;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = {{24{sgn & b[7]}}, b};
      default: r = word;
    endcase
    return r;
  endfunction

  // Pipeline capture with flush > stall > capture priority; counter retires the held entry.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      valid_r    <= 1'b0;
      alu_r      <= 32'h0000_0000;
      mem_r      <= 32'h0000_0000;
      pc8_r      <= 32'h0000_0000;
      dest_r     <= 5'd0;
      regwrite_r <= 1'b0;
      wbsel_r    <= 2'b00;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      retired_r  <= '0;
    end else begin
      if (valid_r && !Stall_IN) begin
        retired_r <= retired_r + CNT_ONE;
      end
      if (Flush_IN) begin
        valid_r <= 1'b0;
      end else if (!Stall_IN) begin
        valid_r    <= Valid_IN;
        alu_r      <= ALUResult_IN;
        mem_r      <= MemData_IN;
        pc8_r      <= PCPlus8_IN;
        dest_r     <= DestReg_IN;
        regwrite_r <= RegWrite_IN;
        wbsel_r    <= WbSel_IN;
        size_r     <= LoadSize_IN;
        signed_r   <= LoadSigned_IN;
      end
    end
  end

  // Writeback source select; an empty stage presents zero data.
  always_comb begin
    load_s  = extract_load(mem_r, alu_r[1:0], size_r, signed_r);
    wdata_s = 32'h0000_0000;
    if (valid_r) begin
      case (wbsel_r)
        2'b01:   wdata_s = load_s;
        2'b10:   wdata_s = pc8_r;
        default: wdata_s = alu_r;
      endcase
    end else begin
      wdata_s = 32'h0000_0000;
    end
    wen_s = valid_r & regwrite_r & (dest_r != 5'd0);
  end

  assign WriteData_OUT     = wdata_s;
  assign WriteRegister_OUT = dest_r;
  assign WriteEnable_OUT   = wen_s;
  assign Valid_OUT         = valid_r;
  assign Retired_OUT       = retired_r;

`ifdef WB_BYPASS_EN
  logic [31:0] prev_wdata_r;
  logic [4:0]  prev_wreg_r;
  logic        prev_wen_r;

  // Remember the write leaving WB so ID can forward it across the same-edge hazard.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      prev_wdata_r <= 32'h0000_0000;
      prev_wreg_r  <= 5'd0;
      prev_wen_r   <= 1'b0;
    end else if (!Stall_IN) begin
      prev_wdata_r <= wdata_s;
      prev_wreg_r  <= dest_r;
      prev_wen_r   <= wen_s;
    end else begin
      prev_wdata_r <= prev_wdata_r;
      prev_wreg_r  <= prev_wreg_r;
      prev_wen_r   <= prev_wen_r;
    end
  end

  assign PrevWriteData_OUT     = prev_wdata_r;
  assign PrevWriteRegister_OUT = prev_wreg_r;
  assign PrevWriteEnable_OUT   = prev_wen_r;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback-select logic for the 5-stage MIPS pipeline.
- Captures the MEM-stage results, performs load byte/half extraction and extension, and selects the writeback value.
- Drives the register file write port: write data, write register and write enable.
- Also keeps a retired-instruction counter for the verification harness.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- CLOCK  in  1  pipeline clock, rising-edge active.
- RESET  in  1  asynchronous, active-low reset.
- Stall_IN  in  1  hold the current contents; do not capture.
- Flush_IN  in  1  squash the incoming instruction; captured entry becomes invalid.
- Valid_IN  in  1  MEM stage holds a real instruction.
- ALUResult_IN  in  32  ALU result; also the load address.
- MemData_IN  in  32  raw data-memory read word.
- PCPlus8_IN  in  32  link value for JAL/JALR.
- DestReg_IN  in  5  destination register number.
- RegWrite_IN  in  1  instruction writes a register.
- WbSel_IN  in  2  writeback source: 00 ALU, 01 memory, 10 link, 11 reserved (treated as ALU).
- LoadSize_IN  in  2  load size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- LoadSigned_IN  in  1  sign-extend a sub-word load; 0 means zero-extend.
- WriteData_OUT  out  32  register file write data.
- WriteRegister_OUT  out  5  register file write address.
- WriteEnable_OUT  out  1  register file write enable.
- Valid_OUT  out  1  stage holds a valid instruction.
- Retired_OUT  out  CNT_WIDTH  count of instructions retired.

Behaviour:
- Reset (RESET low, asynchronous): all pipeline registers and Retired_OUT clear to 0.
  - Valid_OUT=0, WriteEnable_OUT=0, WriteData_OUT=0, WriteRegister_OUT=0.
- Rising CLOCK, RESET high, priority order:
  - Flush_IN=1: Valid register <=0; data fields may load but are don't-care. Flush wins over Stall_IN.
  - Stall_IN=1, no flush: every register holds its value.
  - Otherwise: capture all *_IN fields; Valid register <= Valid_IN.
- Latency: one cycle from the MEM-stage inputs to the outputs.
- Outputs are combinational from the registers only; there is no path from *_IN to any output.
- WriteEnable_OUT = Valid_r & RegWrite_r & (DestReg_r != 0). A write to $0 is never issued.
- WriteRegister_OUT = DestReg_r.
- Load extraction is big-endian and uses the byte offset off = ALUResult_r[1:0]:
  - Byte: off 0 selects bits 31:24, off 1 selects 23:16, off 2 selects 15:8, off 3 selects 7:0.
  - Half: off[1]=0 selects bits 31:16, off[1]=1 selects 15:0; off[0] is ignored.
  - Result is extended to 32 bits, sign- or zero-extended per LoadSigned_r.
- WriteData_OUT: the ALU value, the extracted load value or PCPlus8 per WbSel_r. It is 0 whenever Valid_r=0.
- Stall with a valid entry:
  - The entry stays and WriteEnable_OUT stays asserted.
  - The register file is rewritten with the identical value each cycle, which is idempotent.
- Retired counter:
  - At a rising edge with Valid_r=1 and Stall_IN=0, the held instruction leaves WB and Retired_OUT increments by 1.
  - A flush in the same cycle does not block this; flush affects only the incoming entry.
  - Wraps from all-ones to 0.
- Reset mid-stall or mid-flush: reset dominates; the next capture needs a clock edge with RESET high.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, three extra registered outputs are added: PrevWriteData_OUT (32), PrevWriteRegister_OUT (5), PrevWriteEnable_OUT (1).
  - At each rising edge with Stall_IN=0, they take the current WriteData_OUT, WriteRegister_OUT and WriteEnable_OUT.
  - Under stall they hold. Reset clears all three to 0.
  - The ID-stage forwarding unit uses them to cover the write-in-WB/read-in-ID same-edge hazard.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, then ALU op: ALUResult=0x0000_1234, Dest=5, RegWrite=1, WbSel=00 -> next cycle WriteEnable=1, WriteRegister=5, WriteData=0x0000_1234, Retired=0.
- Signed byte load: MemData=0x1280_FF7F, ALUResult=0x100 + off 2, LoadSize=10, LoadSigned=1 -> WriteData=0xFFFF_FFFF; the same with off 3 -> 0x0000_007F.
- Unsigned half load: MemData=0x8001_ABCD, off 0, LoadSigned=0 -> 0x0000_8001; with off 2 -> 0x0000_ABCD.
- Write to $0: Dest=0, RegWrite=1 -> WriteEnable=0. Link op with PCPlus8=0x0040_0010, WbSel=10, Dest=31 -> WriteData=0x0040_0010.
- Stall for 3 cycles on a valid entry -> outputs unchanged and Retired unchanged during the stall; Retired increments by 1 on the first unstalled edge. Flush together with Stall -> Valid_OUT=0 on the next cycle.
- Assert RESET mid-stream with Valid=1 -> all outputs 0 immediately, before any clock edge. With WB_BYPASS_EN defined: back-to-back writes to reg 3 of 0xA then 0xB -> PrevWriteData shows 0xA while WriteData shows 0xB.
